sr_driver: RTL

Synchronous excitation sequencer for an external SR bistable (asynchronous latch, level-triggered, master-slave or edge-triggered). It accepts a target bit through a valid/ready handshake and drives the bistable's `s`/`r` inputs with a pulse of fixed width. It then watches the bistable's `q` output and reports `done` on success or `err` on timeout. It sits between a controller and any SR bistable under test or in use, so a design can write to an SR storage element without ever raising `s` and `r` together.

---
 rtl/sr_driver.sv | 131 +++++++++++++
 1 files changed

// File: rtl/sr_driver.sv
`default_nettype none
// ============================================================================
// Module   : sr_driver
// Purpose  : Drives an external SR bistable with a fixed-width, mutually
//            exclusive set/reset pulse, then watches q for done / timeout.
//            Optional macro SR_DRIVER_SYNC_EN adds a 2-flop synchronizer on q.
// Revision : 1.0 - initial release
// ============================================================================
module sr_driver #(
    parameter int PW = 2,
    parameter int TO = 8
) (
    input  logic ck,
    input  logic reset,
    input  logic d,
    input  logic valid,
    output logic ready,
    output logic s,
    output logic r,
    input  logic q,
    output logic done,
    output logic err
);

    localparam int c_cnt_max = (PW > TO) ? PW : TO;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam logic [c_cnt_w-1:0] c_pw_last = c_cnt_w'(PW - 1);
    localparam logic [c_cnt_w-1:0] c_to_last = c_cnt_w'(TO - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PULSE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic                 r_tgt;
    logic                 w_tgt_nxt;
    logic                 w_qs;
    logic                 r_s;
    logic                 r_r;
    logic                 r_done;
    logic                 r_err;

`ifdef SR_DRIVER_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], q};
        end
    end

    assign w_qs = r_sync[1];
`else
    // q is only safe to use directly against a zero-delay model.
    assign w_qs = q;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tgt_nxt   = r_tgt;
        case (r_state)
            S_IDLE: begin
                if (valid) begin
                    w_tgt_nxt   = d;
                    w_cnt_nxt   = '0;
                    w_state_nxt = (w_qs == d) ? S_DONE : S_PULSE;
                end
            end
            S_PULSE: begin
                if (r_cnt == c_pw_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_WAIT;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_WAIT: begin
                if (w_qs == r_tgt) begin
                    w_state_nxt = S_DONE;
                end else if (r_cnt == c_to_last) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so s and r can never overlap
    // or glitch, and reset clears them without waiting for a clock.
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_tgt   <= 1'b0;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tgt   <= w_tgt_nxt;
            r_s     <= (w_state_nxt == S_PULSE) &&  w_tgt_nxt;
            r_r     <= (w_state_nxt == S_PULSE) && !w_tgt_nxt;
            r_done  <= (w_state_nxt == S_DONE);
            r_err   <= (w_state_nxt == S_ERR);
        end
    end

    assign ready = (r_state == S_IDLE);
    assign s     = r_s;
    assign r     = r_r;
    assign done  = r_done;
    assign err   = r_err;

endmodule
`default_nettype wire
